// File: rtl/mem_responder.sv
// Word-addressed memory responder for a CPU MAR/MDR datapath, with a WAIT_STATES access delay and a one-cycle Done pulse.
// Every memory word starts at zero; there is no file dependency.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] MARaddr,
  input  logic [31:0]       MDRdata,
  output logic [31:0]       Mdatain,
  output logic              Done,
  output logic              Busy,
  output logic              Err
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdat;
  logic              r_is_rd;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_start;
  logic              w_conflict;
  logic              w_commit;
  logic              w_acc_rd;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [31:0]       w_acc_dat;

  logic [31:0] r_mem [DEPTH] = '{default: 32'h0};

  assign w_start    = (r_state == S_IDLE) && (Read ^ Write);
  assign w_conflict = (r_state == S_IDLE) && Read && Write;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // With zero wait states the access completes on the request edge itself,
  // so the access path bypasses the latches and uses the live inputs.
  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_commit   = 1'b0;
    w_acc_rd   = r_is_rd;
    w_acc_addr = r_addr;
    w_acc_dat  = r_wdat;
    Done       = 1'b0;
    Busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        Busy       = 1'b0;
        w_acc_rd   = Read;
        w_acc_addr = MARaddr;
        w_acc_dat  = MDRdata;
        if (w_start) begin
          if (WS == 4'd0) begin
            w_next   = S_DONE;
            w_commit = 1'b1;
          end else begin
            w_next    = S_WAIT;
            w_cnt_nxt = WS;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_next   = S_DONE;
          w_commit = 1'b1;
        end
      end
      S_DONE: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next    = S_IDLE;
        w_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_addr  <= '0;
      r_wdat  <= 32'h0;
      r_is_rd <= 1'b0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr  <= MARaddr;
        r_wdat  <= MDRdata;
        r_is_rd <= Read;
      end
      if (w_commit && w_acc_rd) r_rdata <= r_mem[w_acc_addr];
      if (w_conflict) r_err <= 1'b1;
    end
  end

  // Memory contents survive reset; clear only blocks a commit during reset.
  always_ff @(posedge clock) begin
    if (clear && w_commit && !w_acc_rd) r_mem[w_acc_addr] <= w_acc_dat;
  end

  assign Mdatain = r_rdata;
  assign Err     = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a two-wait-state and a zero-wait-state instance.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clear;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic        a_rd = 0, a_wr = 0;
  logic [8:0]  a_addr = '0;
  logic [31:0] a_wd = '0, a_mdat;
  logic        a_done, a_busy, a_err;

  logic        b_rd = 0, b_wr = 0;
  logic [8:0]  b_addr = '0;
  logic [31:0] b_wd = '0, b_mdat;
  logic        b_done, b_busy, b_err;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(9), .WAIT_STATES(2)) dut_a (
    .clock(clk), .clear(clear), .Read(a_rd), .Write(a_wr), .MARaddr(a_addr),
    .MDRdata(a_wd), .Mdatain(a_mdat), .Done(a_done), .Busy(a_busy), .Err(a_err));

  mem_responder #(.ADDR_W(9), .WAIT_STATES(0)) dut_b (
    .clock(clk), .clear(clear), .Read(b_rd), .Write(b_wr), .MARaddr(b_addr),
    .MDRdata(b_wd), .Mdatain(b_mdat), .Done(b_done), .Busy(b_busy), .Err(b_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitors: every Done pulse must match the next expected Mdatain.
  always @(negedge clk) begin
    if (a_done === 1'b1) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_unexpected_done: got Done=1, want no pending request");
      end else chk("a_mdatain_at_done", a_mdat, qa.pop_front());
    end
    if (b_done === 1'b1) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected_done: got Done=1, want no pending request");
      end else chk("b_mdatain_at_done", b_mdat, qb.pop_front());
    end
  end

  task automatic req_a(input logic rd, input logic wr, input logic [8:0] addr,
                       input logic [31:0] data, input logic [31:0] exp);
    @(negedge clk);
    a_rd = rd; a_wr = wr; a_addr = addr; a_wd = data;
    qa.push_back(exp);
    @(posedge clk); #1;
    // Scramble inputs mid-request; they must be ignored.
    a_rd = 0; a_wr = 0; a_addr = ~addr; a_wd = ~data;
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      chk("a_busy_inflight", 32'(a_busy), 32'd1);
      chk("a_done_timing", 32'(a_done), (i == 2) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("a_busy_idle", 32'(a_busy), 32'd0);
    chk("a_done_low", 32'(a_done), 32'd0);
    chk("a_mdatain_held", a_mdat, exp);
  endtask

  task automatic wr_b(input logic [8:0] addr, input logic [31:0] data);
    @(negedge clk);
    b_wr = 1; b_addr = addr; b_wd = data;
    qb.push_back(32'h0);
    @(posedge clk); #1;
    b_wr = 0;
    @(negedge clk);
    chk("b_wr_done", 32'(b_done), 32'd1);
    chk("b_wr_busy", 32'(b_busy), 32'd1);
    @(negedge clk);
    chk("b_wr_done_low", 32'(b_done), 32'd0);
    chk("b_wr_busy_low", 32'(b_busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b1;
    #1 clear = 1'b0;
    #2;
    chk("rst_a_mdat", a_mdat, 32'h0);
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_err", 32'(a_err), 32'd0);
    chk("rst_b_mdat", b_mdat, 32'h0);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;

    // Zero wait states: back-to-back reads with Read held high.
    wr_b(9'h000, 32'h11111111);
    wr_b(9'h001, 32'h22222222);
    @(negedge clk);
    b_rd = 1; b_addr = 9'h000;
    qb.push_back(32'h11111111);
    qb.push_back(32'h22222222);
    @(posedge clk); #1;
    b_addr = 9'h001;
    @(negedge clk); chk("b_b2b_done0", 32'(b_done), 32'd1);
    @(negedge clk); chk("b_b2b_gap", 32'(b_done), 32'd0);
    @(negedge clk); chk("b_b2b_done1", 32'(b_done), 32'd1);
    @(posedge clk); #1;
    b_rd = 0;
    @(negedge clk);
    chk("b_b2b_busy_end", 32'(b_busy), 32'd0);
    chk("b_b2b_mdat_end", b_mdat, 32'h22222222);
    @(negedge clk);
    chk("b_no_extra_done", 32'(b_done), 32'd0);

    // Two wait states: write then read-back.
    req_a(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 32'h0);
    req_a(1'b1, 1'b0, 9'h010, 32'h0, 32'hDEADBEEF);
    @(negedge clk);
    chk("a_mdat_idle_hold", a_mdat, 32'hDEADBEEF);

    // Read and Write together: sticky error, nothing started.
    @(negedge clk);
    a_rd = 1; a_wr = 1; a_addr = 9'h010; a_wd = 32'h0BAD0BAD;
    @(posedge clk); #1;
    a_rd = 0; a_wr = 0;
    @(negedge clk);
    chk("a_err_set", 32'(a_err), 32'd1);
    chk("a_err_busy", 32'(a_busy), 32'd0);
    @(negedge clk);
    chk("a_err_busy2", 32'(a_busy), 32'd0);
    req_a(1'b1, 1'b0, 9'h010, 32'h0, 32'hDEADBEEF);
    chk("a_err_sticky", 32'(a_err), 32'd1);

    // Reset while a write is waiting: aborted, memory untouched.
    @(negedge clk);
    a_wr = 1; a_addr = 9'h020; a_wd = 32'h12345678;
    @(posedge clk); #1;
    a_wr = 0;
    @(posedge clk); #1;
    clear = 1'b0;
    #1;
    chk("abort_mdat", a_mdat, 32'h0);
    chk("abort_done", 32'(a_done), 32'd0);
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_err", 32'(a_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    req_a(1'b1, 1'b0, 9'h020, 32'h0, 32'h0);
    req_a(1'b1, 1'b0, 9'h010, 32'h0, 32'hDEADBEEF);

    repeat (3) @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 9, address width; memory depth is 2^ADDR_W words of 32 bits.
REQ-002 Parameter WAIT_STATES, default 2, legal 0..15, extra cycles inserted before each access completes.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 clear  input  1  reset; asynchronous, active-low.
REQ-005 Read  input  1  read request strobe from CPU control.
REQ-006 Write  input  1  write request strobe from CPU control.
REQ-007 MARaddr  input  ADDR_W  word address driven by the MAR.
REQ-008 MDRdata  input  32  write data driven by the MDR output.
REQ-009 Mdatain  output  32  read data returned to the MDR's memory-side input.
REQ-010 Done  output  1  one-cycle completion pulse.
REQ-011 Busy  output  1  high while a request is in flight.
REQ-012 Err  output  1  sticky flag for an illegal request.

Function
REQ-013 FSM states are IDLE, WAIT and DONE; encoding is implementation choice.
REQ-014 In IDLE, sampling exactly one of Read or Write high at edge E0 latches MARaddr, MDRdata and the operation type.
REQ-015 At E0 the FSM goes to WAIT with counter = WAIT_STATES, or to DONE directly if WAIT_STATES = 0.
REQ-016 In WAIT, the counter decrements each edge; at the edge where it reaches 0, the FSM goes to DONE.
REQ-017 The memory access uses the latched address and data at the edge entering DONE (edge E0+WAIT_STATES).
REQ-018 Read: Mdatain loads mem[latched address] at that edge.
REQ-019 Write: mem[latched address] loads the latched data at that edge; Mdatain is unchanged.
REQ-020 Done is 1 for exactly the cycle spent in DONE, between edges E0+WAIT_STATES and E0+WAIT_STATES+1.
REQ-021 DONE always returns to IDLE at the next edge; the earliest next request is sampled at edge E0+WAIT_STATES+2.
REQ-022 Busy is 0 in IDLE and 1 in WAIT and DONE.
REQ-023 Mdatain holds its value until the next read completes; it is never updated by writes or idle cycles.
REQ-024 Read, Write, MARaddr and MDRdata are ignored outside IDLE; changing them mid-request does not affect it.
REQ-025 Read and Write both high in IDLE: no request is started, Err is set to 1 and stays 1 until reset, and the FSM stays in IDLE.
REQ-026 A write followed by a read of the same address returns the newly written data.
REQ-027 Address wrap needs no special handling, since every ADDR_W value is a legal location.

Reset
REQ-028 When clear goes low, the block asynchronously forces: state IDLE, counter 0, latched address and data 0, Mdatain 0, Done 0, Busy 0, Err 0.
REQ-029 Reset does not alter memory contents.
REQ-030 Reset before the edge entering DONE discards the pending request; no write is committed and Mdatain keeps its reset value.
REQ-031 The first request after release is sampled at the first rising edge with clear high.

Configuration
REQ-032 Macro MEM_PRELOAD_EN defined: memory is initialised at elaboration from hex file "mem_init.hex", one 32-bit word per line starting at address 0.
REQ-033 Macro MEM_PRELOAD_EN undefined: every memory word is initialised to 32'h0; there is no file dependency.

Verification
REQ-034 WAIT_STATES=2, Write addr 9'h010 data 32'hDEADBEEF at E0 -> Busy 1 for 3 cycles, Done pulses in cycle after E0+2, Mdatain stays 0.
REQ-035 Then Read addr 9'h010 -> Done in cycle after E0'+2 with Mdatain = 32'hDEADBEEF, held after Done falls.
REQ-036 WAIT_STATES=0, back-to-back reads of 9'h000 and 9'h001, requests held high -> Done every 2nd cycle, each sampled at the first IDLE edge.
REQ-037 Read and Write both high in IDLE -> Err=1 sticky, Busy stays 0, no Done, memory unchanged.
REQ-038 Write 32'h12345678 to 9'h020, clear low one cycle after E0 (WAIT_STATES=2) -> all outputs 0 immediately; a later read of 9'h020 returns its prior value (0 without MEM_PRELOAD_EN).
